pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The module SHALL have parameter WD_LIMIT, default 255, the number of consecutive stall cycles after which the watchdog flag is raised.
REQ-002 The module SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The module SHALL have port imem_ready  input  1  fetch data valid this cycle.
REQ-005 The module SHALL have port dmem_active / dmem_ready  input  1 each  MEM-stage access in progress / access completes this cycle.
REQ-006 The module SHALL have port id_rs1, id_rs2  input  5 each  ID-stage source registers; id_use_rs1, id_use_rs2  input  1 each  sources are read.
REQ-007 The module SHALL have port ex_is_load  input  1, ex_rd  input  5  EX-stage load and its destination.
REQ-008 The module SHALL have port br_mispredict  input  1  EX-stage branch resolved against its prediction.
REQ-009 The module SHALL have port load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  stage register enables.
REQ-010 The module SHALL have port flush_if_id, flush_id_ex  output  1 each  load a bubble (NOP, predictor fields 0) instead of upstream data.
REQ-011 The module SHALL have port squash_fetch  output  1  discard the current imem response.
REQ-012 The module SHALL have port stall_cycles, flush_count  output  32 each  saturating performance counters; wd_err  output  1  sticky watchdog flag.

Function
REQ-013 The module SHALL define mem_ok = !dmem_active || dmem_ready, and luse = ex_is_load && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)).
REQ-014 The module SHALL implement FSM states RUN, I_STALL, D_STALL, REDIRECT_WAIT, each entered on a clock edge.
REQ-015 The module SHALL, in any state, de-assert all five loads and both flushes whenever !mem_ok, and take D_STALL next, unless in REDIRECT_WAIT, where it SHALL remain.
REQ-016 The module SHALL, in RUN/I_STALL/D_STALL with mem_ok && !imem_ready && !br_mispredict, de-assert all loads and take I_STALL next.
REQ-017 The module SHALL, with mem_ok && imem_ready && br_mispredict, assert all five loads, assert flush_if_id and flush_id_ex, and take RUN next.
REQ-018 The module SHALL, with mem_ok && !imem_ready && br_mispredict, assert all five loads, assert flush_if_id and flush_id_ex, and take REDIRECT_WAIT next.
REQ-019 The module SHALL, in REDIRECT_WAIT, de-assert all loads; on imem_ready it SHALL assert squash_fetch for that cycle only and take RUN next.
REQ-020 The module SHALL, with mem_ok && imem_ready && !br_mispredict && luse, de-assert load_pc and load_if_id, assert load_id_ex with flush_id_ex, assert load_ex_mem and load_mem_wb, and take RUN next.
REQ-021 The module SHALL, with mem_ok && imem_ready && !br_mispredict && !luse, assert all loads, de-assert the flushes, and take RUN next.
REQ-022 The module SHALL give priority: !mem_ok > br_mispredict > !imem_ready > luse.
REQ-023 The module SHALL assert squash_fetch only as in REQ-019.
REQ-024 The module SHALL increment stall_cycles on each cycle where load_pc is 0, saturating at 32'hFFFF_FFFF.
REQ-025 The module SHALL increment flush_count on each cycle where flush_if_id is 1, saturating at 32'hFFFF_FFFF.
REQ-026 The module SHALL count consecutive cycles with all loads 0 in an internal counter, cleared by any cycle with load_mem_wb = 1.
REQ-027 The module SHALL set wd_err when that counter reaches WD_LIMIT, and hold wd_err until rst.
REQ-028 The module SHALL compute all enable, flush and squash outputs combinationally from state and inputs, with zero-cycle latency.

Reset
REQ-029 The module SHALL, on rst, set state RUN, both counters 0, the watchdog counter 0 and wd_err 0.
REQ-030 The module SHALL, in the rst cycle, drive all loads 1 and both flushes 1 so stage registers fill with bubbles; squash_fetch SHALL be 0.
REQ-031 The module SHALL let rst asserted in any state, including REDIRECT_WAIT, override all transitions and discard any pending squash.

Verification
REQ-032 The bench SHALL check: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1, memories ready -> load_pc=0, load_if_id=0, load_id_ex=1, flush_id_ex=1 for one cycle; stall_cycles +1.
REQ-033 The bench SHALL check: same case with ex_rd=0 -> all loads 1, no flush.
REQ-034 The bench SHALL check: dmem_active=1, dmem_ready=0 for 4 cycles, br_mispredict=1 -> all loads 0 for 4 cycles; the cycle dmem_ready=1 gives all loads 1, both flushes 1; flush_count=1.
REQ-035 The bench SHALL check: br_mispredict=1, imem_ready=0 -> flush cycle, REDIRECT_WAIT for 3 cycles with loads 0; then imem_ready=1 -> squash_fetch=1 for exactly that cycle; next cycle RUN.
REQ-036 The bench SHALL check: WD_LIMIT=8, imem_ready=0 held -> wd_err rises after the 8th stalled cycle and stays 1 after imem_ready returns; clears only on rst.
REQ-037 The bench SHALL check: rst asserted in REDIRECT_WAIT while imem_ready=1 -> squash_fetch=0, next state RUN, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush controller for a classic 5-stage in-order pipeline
// (IF, ID, EX, MEM, WB). Each cycle it decides which stage registers may
// advance, which ones must be loaded with a bubble instead of upstream data,
// and whether the fetch response that arrives now must be thrown away.
// It also keeps two saturating performance counters and a sticky watchdog
// that flags a pipeline that has been frozen for too long.
//
// Parameters
//   WD_LIMIT       number of consecutive fully-frozen cycles that raises wd_err
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   imem_ready     instruction fetch data valid this cycle
//   dmem_active    MEM stage has a data access in flight
//   dmem_ready     that data access completes this cycle
//   id_rs1/id_rs2  ID-stage source register numbers
//   id_use_rs1/2   the corresponding source is actually read
//   ex_is_load     EX stage holds a load
//   ex_rd          destination register of the EX-stage instruction
//   br_mispredict  EX-stage branch resolved against its prediction
//   load_pc .. load_mem_wb   stage register enables
//   flush_if_id, flush_id_ex load a bubble into that stage register
//   squash_fetch   discard the imem response of this cycle
//   stall_cycles   saturating count of cycles with load_pc low
//   flush_count    saturating count of cycles with flush_if_id high
//   wd_err         sticky watchdog flag, cleared only by rst
//
// All enables, flushes and squash_fetch are combinational from the current
// state and inputs so the datapath sees them in the same cycle. The counters
// and wd_err are registered.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned WD_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ready,
    input  logic        dmem_active,
    input  logic        dmem_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        br_mispredict,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        squash_fetch,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic        wd_err
);

    // Controller states.
    localparam logic [1:0] RUN           = 2'd0;
    localparam logic [1:0] I_STALL       = 2'd1;
    localparam logic [1:0] D_STALL       = 2'd2;
    localparam logic [1:0] REDIRECT_WAIT = 2'd3;

    // Watchdog counter only needs to reach WD_LIMIT; it saturates there.
    localparam int WD_W = (WD_LIMIT < 32'd1) ? 32'd1 : $clog2(WD_LIMIT + 32'd1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WD_LIMIT);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    localparam logic [WD_W-1:0] WD_ZERO = WD_W'(0);

    // Stage enable vector ordering: {pc, if_id, id_ex, ex_mem, mem_wb}.
    localparam logic [4:0] LOADS_ALL  = 5'b11111;
    localparam logic [4:0] LOADS_NONE = 5'b00000;
    localparam logic [4:0] LOADS_LUSE = 5'b00111;

    // Saturating 32-bit increment used by both performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic enable);
        logic [31:0] result;
        if (enable && (value != 32'hFFFF_FFFF)) begin
            result = value + 32'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

    logic [1:0]      state_r;
    logic [1:0]      state_next_s;
    logic            mem_ok_s;
    logic            luse_s;
    logic [4:0]      loads_s;
    logic            flush_if_id_s;
    logic            flush_id_ex_s;
    logic            squash_s;
    logic            all_idle_s;
    logic [31:0]     stall_cycles_r;
    logic [31:0]     flush_count_r;
    logic [WD_W-1:0] wd_cnt_r;
    logic [WD_W-1:0] wd_cnt_next_s;
    logic            wd_trip_s;
    logic            wd_err_r;

    // Hazard qualifiers: MEM not blocking, and a load-use dependency on EX.
    always_comb begin
        mem_ok_s = !dmem_active || dmem_ready;
        luse_s   = ex_is_load && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // Next-state and per-cycle enable/flush/squash decode.
    always_comb begin
        state_next_s  = state_r;
        loads_s       = LOADS_NONE;
        flush_if_id_s = 1'b0;
        flush_id_ex_s = 1'b0;
        squash_s      = 1'b0;
        if (rst) begin
            // Load bubbles everywhere so every stage register is cleaned.
            loads_s       = LOADS_ALL;
            flush_if_id_s = 1'b1;
            flush_id_ex_s = 1'b1;
            state_next_s  = RUN;
        end else if (!mem_ok_s) begin
            // A blocked MEM stage freezes everything. A pending redirect
            // must survive the freeze so the stale fetch is still squashed.
            loads_s = LOADS_NONE;
            if (state_r == REDIRECT_WAIT) begin
                state_next_s = REDIRECT_WAIT;
            end else begin
                state_next_s = D_STALL;
            end
        end else begin
            case (state_r)
                REDIRECT_WAIT: begin
                    // The first response after a redirect belongs to the
                    // wrong path; drop it and resume normal operation.
                    loads_s = LOADS_NONE;
                    if (imem_ready) begin
                        squash_s     = 1'b1;
                        state_next_s = RUN;
                    end else begin
                        state_next_s = REDIRECT_WAIT;
                    end
                end
                RUN, I_STALL, D_STALL: begin
                    if (br_mispredict) begin
                        loads_s       = LOADS_ALL;
                        flush_if_id_s = 1'b1;
                        flush_id_ex_s = 1'b1;
                        if (imem_ready) begin
                            state_next_s = RUN;
                        end else begin
                            state_next_s = REDIRECT_WAIT;
                        end
                    end else if (!imem_ready) begin
                        loads_s      = LOADS_NONE;
                        state_next_s = I_STALL;
                    end else if (luse_s) begin
                        // Hold PC and IF/ID, insert a bubble into EX, let
                        // the load itself move on.
                        loads_s       = LOADS_LUSE;
                        flush_id_ex_s = 1'b1;
                        state_next_s  = RUN;
                    end else begin
                        loads_s      = LOADS_ALL;
                        state_next_s = RUN;
                    end
                end
                default: begin
                    loads_s      = LOADS_NONE;
                    state_next_s = RUN;
                end
            endcase
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Watchdog run-length of fully frozen cycles, saturating at WD_MAX.
    always_comb begin
        all_idle_s    = (loads_s == LOADS_NONE);
        wd_cnt_next_s = wd_cnt_r;
        wd_trip_s     = 1'b0;
        if (all_idle_s) begin
            if (wd_cnt_r == WD_MAX) begin
                wd_cnt_next_s = wd_cnt_r;
            end else begin
                wd_cnt_next_s = wd_cnt_r + WD_ONE;
            end
            wd_trip_s = (wd_cnt_next_s == WD_MAX);
        end else if (loads_s[0]) begin
            wd_cnt_next_s = WD_ZERO;
        end else begin
            wd_cnt_next_s = wd_cnt_r;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_r <= WD_ZERO;
            wd_err_r <= 1'b0;
        end else begin
            wd_cnt_r <= wd_cnt_next_s;
            if (wd_trip_s) begin
                wd_err_r <= 1'b1;
            end else begin
                wd_err_r <= wd_err_r;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= 32'd0;
            flush_count_r  <= 32'd0;
        end else begin
            stall_cycles_r <= sat_inc32(stall_cycles_r, !loads_s[4]);
            flush_count_r  <= sat_inc32(flush_count_r, flush_if_id_s);
        end
    end

    assign load_pc      = loads_s[4];
    assign load_if_id   = loads_s[3];
    assign load_id_ex   = loads_s[2];
    assign load_ex_mem  = loads_s[1];
    assign load_mem_wb  = loads_s[0];
    assign flush_if_id  = flush_if_id_s;
    assign flush_id_ex  = flush_id_ex_s;
    assign squash_fetch = squash_s;
    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;
    assign wd_err       = wd_err_r;

endmodule
